// File: rtl/mem_stage_lsu.sv
// M-stage load/store unit: drives a valid/ready data-memory bus, lane-aligns store data,
// formats load data, and stalls the pipeline until each access is acknowledged.
module mem_stage_lsu #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_M,
    input  logic              MemRead_M,
    input  logic              MemWrite_M,
    input  logic [2:0]        funct3_M,
    input  logic [ADDR_W-1:0] ALUResult_M,
    input  logic [31:0]       WriteData_M,
    output logic              bus_req_valid,
    input  logic              bus_req_ready,
    output logic              bus_req_we,
    output logic [ADDR_W-1:0] bus_req_addr,
    output logic [31:0]       bus_req_wdata,
    output logic [3:0]        bus_req_wstrb,
    input  logic              bus_resp_valid,
    input  logic [31:0]       bus_resp_rdata,
    output logic [31:0]       ReadData_M,
    output logic              mem_done,
    output logic              stall_M,
    output logic              mem_fault_M
);

    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        funct3_q;
    logic              we_q;
    logic [31:0]       wdata_q;
    logic [3:0]        wstrb_q;
    logic [31:0]       read_data_q;

    logic              access;
    logic              fault;
    logic              start;
    logic [1:0]        offset;
    logic [3:0]        st_wstrb;
    logic [31:0]       st_wdata;
    logic [31:0]       rdata_shifted;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [31:0]       ld_data;

    assign offset = ALUResult_M[1:0];
    assign access = valid_M & (MemRead_M | MemWrite_M);
    assign start  = (state == IDLE) & access & ~fault;

    // Unsupported encodings and misaligned halfword/word accesses never reach the bus.
    always_comb begin
        fault = 1'b0;
        case (funct3_M)
            3'b011, 3'b110, 3'b111: fault = 1'b1;
            3'b001, 3'b101:         fault = ALUResult_M[0];
            3'b010:                 fault = |ALUResult_M[1:0];
            default:                fault = 1'b0;
        endcase
    end

    always_comb begin
        st_wstrb = 4'h0;
        st_wdata = WriteData_M;
        case (funct3_M[1:0])
            2'b00: begin
                st_wstrb = 4'b0001 << offset;
                st_wdata = {4{WriteData_M[7:0]}};
            end
            2'b01: begin
                st_wstrb = 4'b0011 << offset;
                st_wdata = {2{WriteData_M[15:0]}};
            end
            default: begin
                st_wstrb = 4'hF;
                st_wdata = WriteData_M;
            end
        endcase
        if (!MemWrite_M) begin
            st_wstrb = 4'h0;
        end
    end

    // Load formatting works from the latched address/funct3 so the M inputs may change while stalled.
    always_comb begin
        rdata_shifted = bus_resp_rdata >> {addr_q[1:0], 3'b000};
        ld_byte       = rdata_shifted[7:0];
        ld_half       = addr_q[1] ? bus_resp_rdata[31:16] : bus_resp_rdata[15:0];
        case (funct3_q)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_data = {24'h000000, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_data = {16'h0000, ld_half};
            default: ld_data = bus_resp_rdata;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = REQ;
            REQ:     if (bus_req_ready) state_next = RESP;
            RESP:    if (bus_resp_valid) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            addr_q      <= '0;
            funct3_q    <= 3'b000;
            we_q        <= 1'b0;
            wdata_q     <= 32'h0;
            wstrb_q     <= 4'h0;
            read_data_q <= 32'h0;
        end else begin
            state <= state_next;
            if (start) begin
                addr_q   <= ALUResult_M;
                funct3_q <= funct3_M;
                we_q     <= MemWrite_M;
                wdata_q  <= st_wdata;
                wstrb_q  <= st_wstrb;
            end
            if ((state == RESP) && bus_resp_valid && !we_q) begin
                read_data_q <= ld_data;
            end
        end
    end

    assign bus_req_valid = (state == REQ);
    assign bus_req_we    = we_q;
    assign bus_req_addr  = {addr_q[ADDR_W-1:2], 2'b00};
    assign bus_req_wdata = wdata_q;
    assign bus_req_wstrb = wstrb_q;
    assign ReadData_M    = read_data_q;
    assign mem_done      = (state == DONE);
    assign stall_M       = start | (state == REQ) | (state == RESP);
    assign mem_fault_M   = (state == IDLE) & access & fault;

endmodule
